// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes: LANES inverse S-box lookups per beat over NBEATS beats,
// with a valid/ready handshake on both the input and the output side.
module inv_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NBEATS = 16 / LANES;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    // FIPS-197 inverse S-box, entry 0 in the top byte, one row of 16 entries per line.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [127:0]   work, work_sub, out_reg;
    logic           last_beat;
    logic           accept;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready never depends on in_valid; out_valid never depends on out_ready.
    assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign out_data  = out_reg;
    assign last_beat = (cnt == CW'(NBEATS - 1));

    // Substitute the LANES bytes selected by the beat counter; the rest pass through.
    always_comb begin
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx = int'(cnt) * LANES + l;
            work_sub[127 - 8*idx -: 8] = inv_sbox(work[127 - 8*idx -: 8]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: if (last_beat) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            out_reg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work <= in_data;
                cnt  <= '0;
            end else if (state == BUSY) begin
                work <= work_sub;
                cnt  <= last_beat ? '0 : cnt + CW'(1);
                // The result register only moves on completion so it holds between results.
                if (last_beat) out_reg <= work_sub;
            end
        end
    end

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: known vectors, latency/throughput, backpressure,
// mid-operation reset and random round-trips through a GF(2^8)-derived forward S-box.
module tb_inv_subbytes_seq;

    localparam int LANES  = 4;
    localparam int NBEATS = 16 / LANES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    inv_subbytes_seq #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int accept_cyc;
    bit rand_out = 1'b0;
    logic [127:0] exp_q[$];
    logic [7:0]   fwd_tbl [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // forward S-box built from GF(2^8) inversion plus the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_fwd();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fwd_tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = fwd_tbl[s[127 - 8*i -: 8]];
        return r;
    endfunction

    // scoreboard: compare every output handshake against the expected queue
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with empty queue", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // driver: present d until accepted, then scramble in_data
    task automatic drive(input logic [127:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            if (rand_out) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                timeout_fail("accept");
                break;
            end
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e);
        exp_q.push_back(e);
        drive(d);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            t++;
            if (t > 500) begin
                timeout_fail("drain");
                exp_q.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    // called right after an accept edge; counts edges until out_valid rises
    task automatic measure_latency(input string name);
        int k;
        for (k = 1; k <= NBEATS + 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) break;
        end
        check(name, 128'(k), 128'(NBEATS));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] x_exp, y_exp, orig;
        int prev;

        vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{{16{8'h63}}, {16{8'h00}}};
        vecs[2] = '{{16{8'h16}}, {16{8'hff}}};
        vecs[3] = '{{16{8'h00}}, {16{8'h52}}};
        vecs[4] = '{{16{8'h52}}, {16{8'h48}}};
        vecs[5] = '{128'h63cab7040953d051cd60e0e7ba70e18c, 128'h00102030405060708090a0b0c0d0e0f0};

        build_fwd();

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data",  out_data,        128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // first-result latency and busy flag
        out_ready = 1'b1;
        send(vecs[0].din, vecs[0].dout);
        check("busy_after_accept", 128'(busy), 128'(1));
        measure_latency("latency");
        wait_drain();

        // table vectors as a back-to-back stream; accepts spaced NBEATS+1 apart
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].din, vecs[i].dout);
            if (i > 0) check("stream_spacing", 128'(accept_cyc - prev), 128'(NBEATS + 1));
            prev = accept_cyc;
        end
        wait_drain();

        // backpressure: hold DONE for 20 cycles with a second state waiting
        out_ready = 1'b0;
        x_exp = vecs[5].dout;
        send(vecs[5].din, x_exp);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) timeout_fail("bp_out_valid");
        end
        in_valid = 1'b1;
        in_data  = vecs[2].din;
        y_exp    = vecs[2].dout;
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_out_data",  out_data,        x_exp);
            check("bp_in_ready",  128'(in_ready),  128'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        exp_q.push_back(y_exp);
        @(negedge clk);
        check("bp_in_ready_release", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        check("bp_same_cycle_accept", 128'(busy), 128'(1));
        in_valid = 1'b0;
        in_data  = '1;
        wait_drain();

        // asynchronous reset partway through BUSY discards the state
        drive(vecs[4].din);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_out_data",  out_data,        128'(0));
        check("mid_rst_busy",      128'(busy),      128'(0));
        check("mid_rst_in_ready",  128'(in_ready),  128'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(vecs[0].din, vecs[0].dout);
        measure_latency("latency_after_reset");
        wait_drain();

        // random round-trips with random output backpressure
        rand_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            send(fwd_state(orig), orig);
        end
        rand_out = 1'b0;
        wait_drain();

        repeat (NBEATS + 4) @(posedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
